// File: rtl/dsp_iq_mult_arb.sv
`default_nettype none
// ============================================================================
// Module   : dsp_iq_mult_arb
// Purpose  : Round-robin arbiter that time-shares a single complex (I/Q)
//            multiplier between PORTS requesters. The granted operand pair is
//            forwarded to the multiplier, the requester index is queued in a
//            tag FIFO, and each returning product is steered back to the
//            lane that launched it, strictly in launch order.
// Ports    : clk, rst                       clock, async active-high reset
//            input_{a,b}_{i,q}_tdata        packed requester operands
//            input_tvalid / input_tready    per-requester handshake
//            mult_{a,b}_{i,q}_tdata         operands to the multiplier
//            mult_{a,b}_tvalid / _tready    multiplier operand handshake
//            mult_output_{i,q}_tdata        product from the multiplier
//            mult_output_tvalid / _tready   multiplier product handshake
//            output_{i,q}_tdata             product, replicated on all lanes
//            output_tvalid / output_tready  per-lane product handshake
// Revision : 1.0 - initial release
// ============================================================================
module dsp_iq_mult_arb #(
  parameter int WIDTH     = 16,
  parameter int PORTS     = 4,
  parameter int TAG_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic [PORTS*WIDTH-1:0]     input_a_i_tdata,
  input  logic [PORTS*WIDTH-1:0]     input_a_q_tdata,
  input  logic [PORTS*WIDTH-1:0]     input_b_i_tdata,
  input  logic [PORTS*WIDTH-1:0]     input_b_q_tdata,
  input  logic [PORTS-1:0]           input_tvalid,
  output logic [PORTS-1:0]           input_tready,

  output logic [WIDTH-1:0]           mult_a_i_tdata,
  output logic [WIDTH-1:0]           mult_a_q_tdata,
  output logic                       mult_a_tvalid,
  input  logic                       mult_a_tready,
  output logic [WIDTH-1:0]           mult_b_i_tdata,
  output logic [WIDTH-1:0]           mult_b_q_tdata,
  output logic                       mult_b_tvalid,
  input  logic                       mult_b_tready,

  input  logic [2*WIDTH-1:0]         mult_output_i_tdata,
  input  logic [2*WIDTH-1:0]         mult_output_q_tdata,
  input  logic                       mult_output_tvalid,
  output logic                       mult_output_tready,

  output logic [PORTS*2*WIDTH-1:0]   output_i_tdata,
  output logic [PORTS*2*WIDTH-1:0]   output_q_tdata,
  output logic [PORTS-1:0]           output_tvalid,
  input  logic [PORTS-1:0]           output_tready
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int TAG_W = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0]       C_ST_ARB    = 1'b0;
  localparam logic [0:0]       C_ST_HOLD   = 1'b1;
  localparam logic [TAG_W:0]   C_PORTS     = (TAG_W + 1)'(PORTS);
  localparam logic [CNT_W-1:0] C_TAG_DEPTH = CNT_W'(TAG_DEPTH);

  // (base + off) modulo PORTS; base < PORTS and off < PORTS, so one
  // conditional subtraction is enough even when PORTS is not a power of 2.
  function automatic logic [TAG_W-1:0] wrap_add(input logic [TAG_W-1:0] base,
                                                input int unsigned      off);
    logic [TAG_W:0] s;
    s = {1'b0, base} + (TAG_W + 1)'(off);
    if (s >= C_PORTS) begin
      s = s - C_PORTS;
    end
    return s[TAG_W-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]       state_q,  state_d;
  logic [TAG_W-1:0] grant_q,  grant_d;
  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [TAG_W-1:0] tag_mem_q [TAG_DEPTH];
  logic [TAG_W-1:0] tag_mem_d [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic             w_arb_found;
  logic [TAG_W-1:0] w_arb_idx;
  logic [TAG_W-1:0] w_winner;
  logic             w_any_valid;
  logic             w_full;
  logic             w_empty;
  logic             w_mult_valid;
  logic             w_launch;
  logic [TAG_W-1:0] w_head;
  logic             w_head_ready;
  logic             w_pop;

  // Round-robin search starting at the pointer; first valid requester wins.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (!w_arb_found && input_tvalid[wrap_add(rr_ptr_q, i)]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = wrap_add(rr_ptr_q, i);
      end
    end
  end

  assign w_any_valid = |input_tvalid;
  assign w_full      = (count_q == C_TAG_DEPTH);
  assign w_empty     = (count_q == '0);

  // While holding, the registered grant is used so the multiplier sees
  // stable operands until it accepts them, whatever other lanes do.
  assign w_winner = (state_q == C_ST_HOLD) ? grant_q : w_arb_idx;

  // A full tag FIFO blocks new arbitration. HOLD needs no full check: it is
  // only entered with room in the FIFO, and nothing can be pushed until the
  // held request itself launches.
  assign w_mult_valid = !rst &&
                        (((state_q == C_ST_ARB) && w_any_valid && !w_full) ||
                         (state_q == C_ST_HOLD));

  assign mult_a_tvalid = w_mult_valid;
  assign mult_b_tvalid = w_mult_valid;

  // The multiplier drives both readies identically; requiring both keeps
  // a and b consumed together.
  assign w_launch = w_mult_valid && mult_a_tready && mult_b_tready;

  // Operand mux onto the shared multiplier.
  always_comb begin
    mult_a_i_tdata = '0;
    mult_a_q_tdata = '0;
    mult_b_i_tdata = '0;
    mult_b_q_tdata = '0;
    for (int k = 0; k < PORTS; k++) begin
      if (w_winner == TAG_W'(k)) begin
        mult_a_i_tdata = input_a_i_tdata[k*WIDTH +: WIDTH];
        mult_a_q_tdata = input_a_q_tdata[k*WIDTH +: WIDTH];
        mult_b_i_tdata = input_b_i_tdata[k*WIDTH +: WIDTH];
        mult_b_q_tdata = input_b_q_tdata[k*WIDTH +: WIDTH];
      end
    end
  end

  // Only the winning lane sees ready, and only on the launch cycle.
  always_comb begin
    input_tready = '0;
    for (int k = 0; k < PORTS; k++) begin
      input_tready[k] = w_launch && (w_winner == TAG_W'(k));
    end
  end

  // --------------------------------------------------------------------------
  // Return path: the tag at the FIFO head owns the current product.
  // --------------------------------------------------------------------------
  assign w_head = tag_mem_q[rd_ptr_q];

  always_comb begin
    w_head_ready = 1'b0;
    for (int k = 0; k < PORTS; k++) begin
      if (w_head == TAG_W'(k)) begin
        w_head_ready = output_tready[k];
      end
    end
  end

  // With an empty FIFO a product has no owner; it is neither accepted nor
  // steered to any lane.
  assign mult_output_tready = !rst && !w_empty && w_head_ready;

  always_comb begin
    output_tvalid = '0;
    for (int k = 0; k < PORTS; k++) begin
      output_tvalid[k] = !rst && mult_output_tvalid && !w_empty &&
                         (w_head == TAG_W'(k));
    end
  end

  assign output_i_tdata = {PORTS{mult_output_i_tdata}};
  assign output_q_tdata = {PORTS{mult_output_q_tdata}};

  assign w_pop = mult_output_tvalid && mult_output_tready;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    tag_mem_d = tag_mem_q;

    case (state_q)
      C_ST_ARB: begin
        // Offered but not taken: freeze this grant until the launch.
        if (w_mult_valid && !w_launch) begin
          state_d = C_ST_HOLD;
          grant_d = w_winner;
        end
      end
      C_ST_HOLD: begin
        if (w_launch) begin
          state_d = C_ST_ARB;
        end
      end
      default: begin
        state_d = C_ST_ARB;
      end
    endcase

    if (w_launch) begin
      rr_ptr_d            = wrap_add(w_winner, 1);
      tag_mem_d[wr_ptr_q] = w_winner;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end

    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({w_launch, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= C_ST_ARB;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tag_mem_q <= tag_mem_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dsp_iq_mult_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_iq_mult_arb
// Purpose  : Directed self-checking bench for dsp_iq_mult_arb. A behavioural
//            complex multiplier with a fixed latency sits behind the arbiter;
//            expected lanes and products are derived from the bench's own
//            operand tables and hand-worked launch orders.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_iq_mult_arb;

  localparam int WIDTH     = 16;
  localparam int PORTS     = 4;
  localparam int TAG_DEPTH = 8;
  localparam int LAT       = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [PORTS*WIDTH-1:0]   input_a_i_tdata, input_a_q_tdata;
  logic [PORTS*WIDTH-1:0]   input_b_i_tdata, input_b_q_tdata;
  logic [PORTS-1:0]         input_tvalid, input_tready;
  logic [WIDTH-1:0]         mult_a_i_tdata, mult_a_q_tdata;
  logic [WIDTH-1:0]         mult_b_i_tdata, mult_b_q_tdata;
  logic                     mult_a_tvalid, mult_a_tready;
  logic                     mult_b_tvalid, mult_b_tready;
  logic [2*WIDTH-1:0]       mult_output_i_tdata, mult_output_q_tdata;
  logic                     mult_output_tvalid, mult_output_tready;
  logic [PORTS*2*WIDTH-1:0] output_i_tdata, output_q_tdata;
  logic [PORTS-1:0]         output_tvalid, output_tready;

  logic                     mult_rdy;
  logic signed [WIDTH-1:0]  op_ai [PORTS];
  logic signed [WIDTH-1:0]  op_aq [PORTS];
  logic signed [WIDTH-1:0]  op_bi [PORTS];
  logic signed [WIDTH-1:0]  op_bq [PORTS];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dsp_iq_mult_arb #(.WIDTH(WIDTH), .PORTS(PORTS), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .input_a_i_tdata     (input_a_i_tdata),
    .input_a_q_tdata     (input_a_q_tdata),
    .input_b_i_tdata     (input_b_i_tdata),
    .input_b_q_tdata     (input_b_q_tdata),
    .input_tvalid        (input_tvalid),
    .input_tready        (input_tready),
    .mult_a_i_tdata      (mult_a_i_tdata),
    .mult_a_q_tdata      (mult_a_q_tdata),
    .mult_a_tvalid       (mult_a_tvalid),
    .mult_a_tready       (mult_a_tready),
    .mult_b_i_tdata      (mult_b_i_tdata),
    .mult_b_q_tdata      (mult_b_q_tdata),
    .mult_b_tvalid       (mult_b_tvalid),
    .mult_b_tready       (mult_b_tready),
    .mult_output_i_tdata (mult_output_i_tdata),
    .mult_output_q_tdata (mult_output_q_tdata),
    .mult_output_tvalid  (mult_output_tvalid),
    .mult_output_tready  (mult_output_tready),
    .output_i_tdata      (output_i_tdata),
    .output_q_tdata      (output_q_tdata),
    .output_tvalid       (output_tvalid),
    .output_tready       (output_tready)
  );

  // Pack the per-port operand tables onto the buses.
  always_comb begin
    input_a_i_tdata = '0;
    input_a_q_tdata = '0;
    input_b_i_tdata = '0;
    input_b_q_tdata = '0;
    for (int k = 0; k < PORTS; k++) begin
      input_a_i_tdata[k*WIDTH +: WIDTH] = op_ai[k];
      input_a_q_tdata[k*WIDTH +: WIDTH] = op_aq[k];
      input_b_i_tdata[k*WIDTH +: WIDTH] = op_bi[k];
      input_b_q_tdata[k*WIDTH +: WIDTH] = op_bq[k];
    end
  end

  // --------------------------------------------------------------------------
  // Behavioural multiplier: fixed latency, stalls while its output is held.
  // --------------------------------------------------------------------------
  int          m_wr  = 0;
  int          m_rd  = 0;
  int          m_cyc = 0;
  logic [31:0] m_pi  [64];
  logic [31:0] m_pq  [64];
  int          m_due [64];

  assign mult_a_tready       = mult_rdy;
  assign mult_b_tready       = mult_rdy;
  assign mult_output_tvalid  = (m_rd != m_wr) && (m_due[m_rd % 64] <= m_cyc);
  assign mult_output_i_tdata = m_pi[m_rd % 64];
  assign mult_output_q_tdata = m_pq[m_rd % 64];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wr  <= 0;
      m_rd  <= 0;
      m_cyc <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (mult_a_tvalid && mult_b_tvalid && mult_rdy) begin
        m_pi[m_wr % 64]  <= 32'(int'($signed(mult_a_i_tdata)) * int'($signed(mult_b_i_tdata))
                              - int'($signed(mult_a_q_tdata)) * int'($signed(mult_b_q_tdata)));
        m_pq[m_wr % 64]  <= 32'(int'($signed(mult_a_i_tdata)) * int'($signed(mult_b_q_tdata))
                              + int'($signed(mult_a_q_tdata)) * int'($signed(mult_b_i_tdata)));
        m_due[m_wr % 64] <= m_cyc + LAT;
        m_wr             <= m_wr + 1;
      end
      if (mult_output_tvalid && mult_output_tready) begin
        m_rd <= m_rd + 1;
      end
    end
  end

  // Expected complex product of a port's current operand pair.
  function automatic logic [31:0] exp_pi(input int k);
    return 32'(int'(op_ai[k]) * int'(op_bi[k]) - int'(op_aq[k]) * int'(op_bq[k]));
  endfunction

  function automatic logic [31:0] exp_pq(input int k);
    return 32'(int'(op_ai[k]) * int'(op_bq[k]) + int'(op_aq[k]) * int'(op_bi[k]));
  endfunction

  task automatic load_ops();
    for (int k = 0; k < PORTS; k++) begin
      op_ai[k] = 16'(10 + k);
      op_aq[k] = -16'(3 + k);
      op_bi[k] = 16'(7 - 2 * k);
      op_bq[k] = 16'(5 + k);
    end
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    input_tvalid  = 4'b1111;
    output_tready = 4'b1111;
    @(negedge clk);
    n_checks++;
    if ({mult_a_tvalid, mult_b_tvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mult_valid: got %b%b expected 00", mult_a_tvalid, mult_b_tvalid);
    end
    n_checks++;
    if (input_tready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_input_tready: got %b expected 0000", input_tready);
    end
    n_checks++;
    if (output_tvalid !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_output_tvalid: got %b expected 0000", output_tvalid);
    end
    n_checks++;
    if (mult_output_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mult_output_tready: got %b expected 0", mult_output_tready);
    end
    input_tvalid = 4'b0000;
  endtask

  task automatic test_single();
    int got = 0;
    @(posedge clk); #1;
    op_ai[1] = 16'sd3; op_aq[1] = 16'sd4;
    op_bi[1] = 16'sd5; op_bq[1] = -16'sd2;
    input_tvalid = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (input_tready !== 4'b0010 || mult_a_i_tdata !== 16'd3 || mult_b_q_tdata !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL single_launch: got ready=%b a_i=%h b_q=%h expected 0010 0003 fffe",
               input_tready, mult_a_i_tdata, mult_b_q_tdata);
    end
    @(posedge clk); #1;
    input_tvalid = 4'b0000;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (output_tvalid != 4'b0000) begin
        n_checks++;
        if (got != 0 || output_tvalid !== 4'b0010 || output_i_tdata[63:32] !== 32'd23 ||
            output_q_tdata[63:32] !== 32'd14) begin
          n_fail++;
          $display("FAIL single_return: got valid=%b I=%0d Q=%0d expected 0010 I=23 Q=14 once",
                   output_tvalid, $signed(output_i_tdata[63:32]), $signed(output_q_tdata[63:32]));
        end
        got++;
      end
    end
    n_checks++;
    if (got != 1) begin
      n_fail++;
      $display("FAIL single_count: got %0d products expected 1", got);
    end
  endtask

  // Pointer is 2 after the single test, so launches run 2,3,0,1,...
  task automatic test_fairness();
    @(posedge clk); #1;
    load_ops();
    input_tvalid = 4'b1111;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          n_checks++;
          if (input_tready !== 4'(1 << ((2 + i) % 4)) ||
              mult_a_i_tdata !== op_ai[(2 + i) % 4]) begin
            n_fail++;
            $display("FAIL fair_launch[%0d]: got ready=%b a_i=%h expected %b %h", i,
                     input_tready, mult_a_i_tdata, 4'(1 << ((2 + i) % 4)), op_ai[(2 + i) % 4]);
          end
        end
        @(posedge clk); #1;
        input_tvalid = 4'b0000;
      end
      begin
        int got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
          @(negedge clk);
          if (output_tvalid != 4'b0000) begin
            int ln = (2 + got) % 4;
            n_checks++;
            if (output_tvalid !== 4'(1 << ln) || output_i_tdata[ln*32 +: 32] !== exp_pi(ln) ||
                output_q_tdata[ln*32 +: 32] !== exp_pq(ln)) begin
              n_fail++;
              $display("FAIL fair_return[%0d]: got valid=%b I=%h Q=%h expected lane %0d I=%h Q=%h",
                       got, output_tvalid, output_i_tdata[ln*32 +: 32],
                       output_q_tdata[ln*32 +: 32], ln, exp_pi(ln), exp_pq(ln));
            end
            got++;
          end
        end
        n_checks++;
        if (got != 8) begin
          n_fail++;
          $display("FAIL fair_count: got %0d products expected 8", got);
        end
      end
    join
  endtask

  // Pointer is 2: port 3 wins, is held while the multiplier stalls, and
  // port 0 (valid from cycle 2) must wait for it.
  task automatic test_stall_hold();
    int got = 0;
    @(posedge clk); #1;
    mult_rdy     = 1'b0;
    input_tvalid = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) input_tvalid = 4'b1001;
      @(negedge clk);
      n_checks++;
      if (mult_a_tvalid !== 1'b1 || mult_a_i_tdata !== op_ai[3] || input_tready !== 4'b0000) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got valid=%b a_i=%h ready=%b expected 1 %h 0000",
                 i, mult_a_tvalid, mult_a_i_tdata, input_tready, op_ai[3]);
      end
      @(posedge clk); #1;
    end
    mult_rdy = 1'b1;
    @(negedge clk);
    n_checks++;
    if (input_tready !== 4'b1000) begin
      n_fail++;
      $display("FAIL stall_release: got ready=%b expected 1000", input_tready);
    end
    @(posedge clk); #1;
    input_tvalid = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (input_tready !== 4'b0001) begin
      n_fail++;
      $display("FAIL stall_next: got ready=%b expected 0001", input_tready);
    end
    @(posedge clk); #1;
    input_tvalid = 4'b0000;
    for (int c = 0; c < 20 && got < 2; c++) begin
      @(negedge clk);
      if (output_tvalid != 4'b0000) begin
        int ln = (got == 0) ? 3 : 0;
        n_checks++;
        if (output_tvalid !== 4'(1 << ln) || output_i_tdata[ln*32 +: 32] !== exp_pi(ln)) begin
          n_fail++;
          $display("FAIL stall_return[%0d]: got valid=%b I=%h expected lane %0d I=%h",
                   got, output_tvalid, output_i_tdata[ln*32 +: 32], ln, exp_pi(ln));
        end
        got++;
      end
    end
    n_checks++;
    if (got != 2) begin
      n_fail++;
      $display("FAIL stall_count: got %0d products expected 2", got);
    end
  endtask

  // Pointer is 1. Port 2 goes first, then all ports: 2,3,0,1,2,3,0,1 fills
  // the tag FIFO while lane 2 (the head) refuses its product.
  task automatic test_backpressure();
    int got = 0;
    @(posedge clk); #1;
    output_tready = 4'b1011;
    input_tvalid  = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (input_tready !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_first: got ready=%b expected 0100", input_tready);
    end
    @(posedge clk); #1;
    input_tvalid = 4'b1111;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_checks++;
      if (input_tready !== 4'(1 << ((3 + i) % 4))) begin
        n_fail++;
        $display("FAIL bp_launch[%0d]: got ready=%b expected %b", i, input_tready,
                 4'(1 << ((3 + i) % 4)));
      end
    end
    @(negedge clk);
    n_checks++;
    if (mult_a_tvalid !== 1'b0 || input_tready !== 4'b0000 || mult_output_tready !== 1'b0 ||
        output_tvalid !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_full: got mvalid=%b ready=%b oready=%b ovalid=%b expected 0 0000 0 0100",
               mult_a_tvalid, input_tready, mult_output_tready, output_tvalid);
    end
    @(posedge clk); #1;
    input_tvalid  = 4'b0000;
    output_tready = 4'b1111;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      if (output_tvalid != 4'b0000) begin
        int ln = (2 + got) % 4;
        n_checks++;
        if (output_tvalid !== 4'(1 << ln) || output_q_tdata[ln*32 +: 32] !== exp_pq(ln)) begin
          n_fail++;
          $display("FAIL bp_drain[%0d]: got valid=%b Q=%h expected lane %0d Q=%h",
                   got, output_tvalid, output_q_tdata[ln*32 +: 32], ln, exp_pq(ln));
        end
        got++;
      end
    end
    n_checks++;
    if (got != 8) begin
      n_fail++;
      $display("FAIL bp_count: got %0d products expected 8", got);
    end
  endtask

  task automatic test_reset_mid();
    int got = 0;
    @(posedge clk); #1;
    output_tready = 4'b0000;
    input_tvalid  = 4'b1111;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({mult_a_tvalid, mult_b_tvalid, input_tready, output_tvalid, mult_output_tready} !== 11'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got mv=%b%b ir=%b ov=%b mor=%b expected all 0",
               mult_a_tvalid, mult_b_tvalid, input_tready, output_tvalid, mult_output_tready);
    end
    @(posedge clk); #1;
    rst           = 1'b0;
    output_tready = 4'b1111;
    @(negedge clk);
    n_checks++;
    if (input_tready !== 4'b0001 || output_tvalid !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_restart: got ready=%b ovalid=%b expected 0001 0000",
               input_tready, output_tvalid);
    end
    @(posedge clk); #1;
    input_tvalid = 4'b0000;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (output_tvalid != 4'b0000) begin
        n_checks++;
        if (got != 0 || output_tvalid !== 4'b0001 || output_i_tdata[31:0] !== exp_pi(0)) begin
          n_fail++;
          $display("FAIL rstmid_return: got valid=%b I=%h expected 0001 I=%h once",
                   output_tvalid, output_i_tdata[31:0], exp_pi(0));
        end
        got++;
      end
    end
    n_checks++;
    if (got != 1) begin
      n_fail++;
      $display("FAIL rstmid_count: got %0d products expected 1", got);
    end
  endtask

  // Pointer is 1; 40 back-to-back launches with continuous returns.
  task automatic test_wrap();
    @(posedge clk); #1;
    input_tvalid = 4'b1111;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          n_checks++;
          if (input_tready !== 4'(1 << ((1 + i) % 4))) begin
            n_fail++;
            $display("FAIL wrap_launch[%0d]: got ready=%b expected %b", i, input_tready,
                     4'(1 << ((1 + i) % 4)));
          end
        end
        @(posedge clk); #1;
        input_tvalid = 4'b0000;
      end
      begin
        int got = 0;
        for (int c = 0; c < 100 && got < 40; c++) begin
          @(negedge clk);
          if (output_tvalid != 4'b0000) begin
            int ln = (1 + got) % 4;
            n_checks++;
            if (output_tvalid !== 4'(1 << ln) || output_i_tdata[ln*32 +: 32] !== exp_pi(ln) ||
                output_q_tdata[ln*32 +: 32] !== exp_pq(ln)) begin
              n_fail++;
              $display("FAIL wrap_return[%0d]: got valid=%b I=%h Q=%h expected lane %0d I=%h Q=%h",
                       got, output_tvalid, output_i_tdata[ln*32 +: 32],
                       output_q_tdata[ln*32 +: 32], ln, exp_pi(ln), exp_pq(ln));
            end
            got++;
          end
        end
        n_checks++;
        if (got != 40) begin
          n_fail++;
          $display("FAIL wrap_count: got %0d products expected 40", got);
        end
      end
    join
  endtask

  initial begin
    rst           = 1'b1;
    mult_rdy      = 1'b1;
    input_tvalid  = 4'b0000;
    output_tready = 4'b0000;
    load_ops();
    repeat (2) @(posedge clk);
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    test_single();
    test_fairness();
    test_stall_hold();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/dsp_iq_mult_arb.md
Name: dsp_iq_mult_arb

Overview:
Round-robin arbiter that time-shares one dsp_iq_mult instance between PORTS requesters.
- Each requester presents a complex operand pair (a, b) on one AXI-stream-style channel.
- The arbiter forwards the granted pair to the multiplier and records the requester index in a tag FIFO.
- It steers each product back to the requester's output lane, in order.
- It sits between the requester datapaths and the shared multiplier; all three share clk and rst.

Parameters:
WIDTH, 16, operand component width; products are 2*WIDTH.
PORTS, 4, number of requesters, 2..16.
TAG_DEPTH, 8, tag FIFO depth; power of 2, at least the multiplier pipeline depth plus 1.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
input_a_i_tdata  in  PORTS*WIDTH  operand a, I component; lane k at [k*WIDTH +: WIDTH]
input_a_q_tdata  in  PORTS*WIDTH  operand a, Q component
input_b_i_tdata  in  PORTS*WIDTH  operand b, I component
input_b_q_tdata  in  PORTS*WIDTH  operand b, Q component
input_tvalid  in  PORTS  per-requester valid, covers a and b together
input_tready  out  PORTS  per-requester ready
mult_a_i_tdata, mult_a_q_tdata  out  WIDTH each  operand a to multiplier
mult_a_tvalid  out  1  operand a valid
mult_a_tready  in  1  operand a ready
mult_b_i_tdata, mult_b_q_tdata  out  WIDTH each  operand b to multiplier
mult_b_tvalid  out  1  operand b valid
mult_b_tready  in  1  operand b ready
mult_output_i_tdata, mult_output_q_tdata  in  2*WIDTH each  product from multiplier
mult_output_tvalid  in  1  product valid
mult_output_tready  out  1  product ready
output_i_tdata, output_q_tdata  out  PORTS*2*WIDTH each  product per lane; every lane carries the same multiplier data
output_tvalid  out  PORTS  per-lane valid
output_tready  in  PORTS  per-lane ready

Behaviour:
- Registers: state (ARB/HOLD), grant index, round-robin pointer, tag FIFO (TAG_DEPTH x clog2(PORTS), read/write pointers, count).
- Reset (async, rst high): state=ARB, pointer=0, FIFO empty.
  - While rst is high, every valid and ready output is 0: mult_a_tvalid, mult_b_tvalid, input_tready, output_tvalid, mult_output_tready.
  - The multiplier is reset by the same rst, so in-flight products are discarded with their tags.
- Grant selection:
  - In ARB, winner = first k with input_tvalid[k]=1, searching pointer, pointer+1, ... modulo PORTS (combinational).
  - In HOLD, winner = registered grant.
- Multiplier valid:
  - mult_a_tvalid = mult_b_tvalid = (ARB and any input_tvalid and FIFO not full) or HOLD.
  - Mult data = winner lane, muxed.
- Launch = mult_a_tvalid & mult_a_tready & mult_b_tready.
  - A launch consumes both operands; the multiplier asserts both readies identically.
- input_tready[k] = launch and winner==k. All other lanes are 0.
- State transitions:
  - ARB with valid asserted and no launch: register grant=winner, go to HOLD. Grant and data stay stable until launch; new requests are ignored.
  - HOLD with launch: go to ARB.
  - ARB with launch: stay in ARB. Back-to-back launches are allowed, one per cycle.
  - On every launch: pointer = winner+1 modulo PORTS, push winner index into the tag FIFO.
- HOLD is entered only when the FIFO is not full, and the FIFO cannot fill without a launch, so no full check is needed in HOLD.
- Return path:
  - head = FIFO read data.
  - output_tvalid[k] = mult_output_tvalid and FIFO not empty and head==k.
  - mult_output_tready = FIFO not empty and output_tready[head].
  - Pop on mult_output_tvalid & mult_output_tready.
- Ordering is head-of-line: a stalled lane blocks all returns behind it.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo TAG_DEPTH.
- mult_output_tvalid while FIFO empty is a protocol violation. mult_output_tready stays 0 and no output lane asserts valid.
- Latency: arbiter adds 0 cycles in either direction (combinational mux/steer). End-to-end latency equals the multiplier latency.

Test Plan:
- Single product: port 1 sends a=(3,4), b=(5,-2), all ready -> lane 1 gets I=23, Q=14 with output_tvalid=0010; lanes 0, 2, 3 never valid.
- Fairness: all 4 ports continuously valid, all ready -> launches 0,1,2,3,0,1,... one per cycle; products return on lanes in the same order.
- Stall hold: port 3 granted with mult_a_tready=0 for 5 cycles, port 0 asserts valid at cycle 2 -> mult data stays port 3's and input_tready=0; on ready, port 3 launches, then port 0 next.
- Backpressure/full: output_tready[2]=0 with head tag 2, all inputs valid -> mult_output_tready=0; after 8 outstanding launches mult_a_tvalid=0 and input_tready=0000; releasing output_tready[2] drains in order.
- Reset mid-stream: assert rst with 5 products outstanding -> all valids and readies 0 immediately; after release FIFO empty, pointer 0; with all ports valid the first launch is port 0.
- Wrap/simultaneous: sustain 40 launches with continuous returns -> FIFO pointers wrap 5 times, count stays constant, every product routed to the correct lane.
